// File: rtl/health_tracker.sv
// health_tracker
//   Player health state for the HUD health bar. Health is lowered by collision
//   damage, raised by heal pickups, and a fixed post-hit invulnerability
//   window is tracked in frames (hit=1 while the bar flashes red).
//
//   Optional build macro: HEALTH_TRACKER_REGEN_EN
//     When defined, passive regeneration adds +1 health every REGEN_FRAMES
//     frames while ALIVE and below MAX_HEALTH.
//
//   Ports:
//     clk         pixel clock
//     rst         synchronous active-high reset
//     frame_tick  one-cycle pulse per video frame
//     damage      one-cycle collision pulse, damage_amt sampled with it
//     damage_amt  health to subtract (4 bits)
//     heal        one-cycle pickup pulse, +1 health
//     restart     one-cycle new-game pulse, same effect as rst
//     health      current health, 0..MAX_HEALTH (registered)
//     hit         high while in HIT (registered)
//     dead        high while in DEAD (registered)
module health_tracker #(
  parameter int unsigned MAX_HEALTH   = 10,
  parameter int unsigned HIT_FRAMES   = 30,
  parameter int unsigned REGEN_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       damage,
  input  logic [3:0] damage_amt,
  input  logic       heal,
  input  logic       restart,
  output logic [3:0] health,
  output logic       hit,
  output logic       dead
);

  typedef enum logic [1:0] {ALIVE, HIT, DEAD} state_t;

  localparam logic [3:0] HMAX     = 4'(MAX_HEALTH);
  // Compare against the last count so a 255-frame window never overflows.
  localparam logic [7:0] HIT_LAST = 8'(HIT_FRAMES - 1);

  state_t     state, state_nxt;
  logic [3:0] health_r, health_nxt;
  logic [7:0] frame_cnt, frame_cnt_nxt;
  logic       bump;

`ifdef HEALTH_TRACKER_REGEN_EN
  localparam logic [7:0] REGEN_LAST = 8'(REGEN_FRAMES - 1);
  logic [7:0] regen_cnt, regen_cnt_nxt;
`else
  logic [7:0] unused_regen_cfg;
  assign unused_regen_cfg = 8'(REGEN_FRAMES);
`endif

  function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
    if (b >= a) return 4'd0;
    return a - b;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] a);
    if (a >= HMAX) return HMAX;
    return a + 4'd1;
  endfunction

  always_comb begin
    state_nxt     = state;
    health_nxt    = health_r;
    frame_cnt_nxt = frame_cnt;
    bump          = 1'b0;
`ifdef HEALTH_TRACKER_REGEN_EN
    regen_cnt_nxt = regen_cnt;
`endif
    if (restart) begin
      state_nxt     = ALIVE;
      health_nxt    = HMAX;
      frame_cnt_nxt = 8'd0;
`ifdef HEALTH_TRACKER_REGEN_EN
      regen_cnt_nxt = 8'd0;
`endif
    end else begin
      case (state)
        ALIVE: begin
          if (damage && (damage_amt != 4'd0)) begin
            // Any tick in this cycle is deliberately not counted.
            health_nxt    = sat_sub(health_r, damage_amt);
            frame_cnt_nxt = 8'd0;
            state_nxt     = (health_nxt == 4'd0) ? DEAD : HIT;
`ifdef HEALTH_TRACKER_REGEN_EN
            regen_cnt_nxt = 8'd0;
`endif
          end else begin
            // A damage pulse (even of 0) pre-empts heal in the same cycle.
            bump = heal && !damage;
`ifdef HEALTH_TRACKER_REGEN_EN
            // Regen holds at full health; a regen step coinciding with a
            // heal still only adds one.
            if (frame_tick && (health_r != HMAX)) begin
              if (regen_cnt == REGEN_LAST) begin
                regen_cnt_nxt = 8'd0;
                bump          = 1'b1;
              end else begin
                regen_cnt_nxt = regen_cnt + 8'd1;
              end
            end
`endif
            if (bump) health_nxt = sat_inc(health_r);
          end
        end
        HIT: begin
          // Invulnerable: damage is ignored, heal still applies.
          if (heal) health_nxt = sat_inc(health_r);
          if (frame_tick) begin
            if (frame_cnt == HIT_LAST) begin
              state_nxt     = ALIVE;
              frame_cnt_nxt = 8'd0;
            end else begin
              frame_cnt_nxt = frame_cnt + 8'd1;
            end
          end
        end
        DEAD: begin
          health_nxt = 4'd0;
        end
        default: begin
          state_nxt = ALIVE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ALIVE;
      health_r  <= HMAX;
      frame_cnt <= 8'd0;
      hit       <= 1'b0;
      dead      <= 1'b0;
`ifdef HEALTH_TRACKER_REGEN_EN
      regen_cnt <= 8'd0;
`endif
    end else begin
      state     <= state_nxt;
      health_r  <= health_nxt;
      frame_cnt <= frame_cnt_nxt;
      hit       <= (state_nxt == HIT);
      dead      <= (state_nxt == DEAD);
`ifdef HEALTH_TRACKER_REGEN_EN
      regen_cnt <= regen_cnt_nxt;
`endif
    end
  end

  assign health = health_r;

endmodule

// File: tb/tb_health_tracker.sv
module tb_health_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       damage = 1'b0;
  logic [3:0] damage_amt = 4'd0;
  logic       heal = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] health;
  logic       hit;
  logic       dead;

  int ncmp = 0;
  int nerr = 0;

  // Scoreboard: {health, hit, dead}
  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];
  string      tag_q[$];

  health_tracker #(
    .MAX_HEALTH  (10),
    .HIT_FRAMES  (30),
    .REGEN_FRAMES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .damage    (damage),
    .damage_amt(damage_amt),
    .heal      (heal),
    .restart   (restart),
    .health    (health),
    .hit       (hit),
    .dead      (dead)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, push the expected result, capture the DUT
  // output one time unit after the sampling edge.
  task automatic step(input logic r, input logic rs, input logic d, input logic [3:0] amt,
                      input logic h, input logic t,
                      input logic [3:0] eh, input logic ehit, input logic edead,
                      input string tag);
    rst = r; restart = rs; damage = d; damage_amt = amt; heal = h; frame_tick = t;
    exp_q.push_back({eh, ehit, edead});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    obs_q.push_back({health, hit, dead});
    rst = 0; restart = 0; damage = 0; damage_amt = 0; heal = 0; frame_tick = 0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 4'd10, 0, 0, "reset");
    step(0, 0, 0, 0, 0, 1, 4'd10, 0, 0, "idle_tick");
    while (exp_q.size() > 0) begin
      logic [5:0] e, o; string s;
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = tag_q.pop_front();
      ncmp++;
      if (o !== e) begin
        nerr++;
        $display("FAIL %s: got h=%0d hit=%0b dead=%0b, want h=%0d hit=%0b dead=%0b",
                 s, o[5:2], o[1], o[0], e[5:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_hit_window();
    step(0, 0, 1, 4'd3, 0, 0, 4'd7, 1, 0, "dmg3");
    for (int i = 1; i <= 29; i++)
      step(0, 0, (i % 7) == 0, 4'd5, 0, 1, 4'd7, 1, 0, "hit_tick");
    step(0, 0, 0, 0, 0, 1, 4'd7, 0, 0, "hit_end");
    step(0, 0, 0, 0, 0, 0, 4'd7, 0, 0, "alive_after");
    while (exp_q.size() > 0) begin
      logic [5:0] e, o; string s;
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = tag_q.pop_front();
      ncmp++;
      if (o !== e) begin
        nerr++;
        $display("FAIL %s: got h=%0d hit=%0b dead=%0b, want h=%0d hit=%0b dead=%0b",
                 s, o[5:2], o[1], o[0], e[5:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_death();
    step(0, 0, 1, 4'd5, 0, 0, 4'd2, 1, 0, "dmg5_to2");
    for (int i = 1; i <= 30; i++)
      step(0, 0, 0, 0, 0, 1, 4'd2, i < 30, 0, "wait_tick");
    step(0, 0, 1, 4'd5, 0, 0, 4'd0, 0, 1, "die");
    step(0, 0, 0, 0, 1, 0, 4'd0, 0, 1, "dead_heal");
    step(0, 0, 1, 4'd3, 0, 0, 4'd0, 0, 1, "dead_dmg");
    step(0, 0, 0, 0, 0, 1, 4'd0, 0, 1, "dead_tick");
    step(0, 1, 0, 0, 0, 0, 4'd10, 0, 0, "restart");
    // Saturating subtract from full health with the largest amount.
    step(0, 0, 1, 4'd15, 0, 0, 4'd0, 0, 1, "dmg15_sat");
    step(0, 1, 1, 4'd2, 1, 1, 4'd10, 0, 0, "restart_prio");
    while (exp_q.size() > 0) begin
      logic [5:0] e, o; string s;
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = tag_q.pop_front();
      ncmp++;
      if (o !== e) begin
        nerr++;
        $display("FAIL %s: got h=%0d hit=%0b dead=%0b, want h=%0d hit=%0b dead=%0b",
                 s, o[5:2], o[1], o[0], e[5:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_heal();
    step(0, 0, 0, 0, 1, 0, 4'd10, 0, 0, "heal_sat");
    step(0, 0, 1, 4'd0, 0, 0, 4'd10, 0, 0, "dmg_zero");
    step(0, 0, 1, 4'd6, 0, 0, 4'd4, 1, 0, "dmg6_to4");
    for (int i = 1; i <= 30; i++)
      step(0, 0, 0, 0, 0, 1, 4'd4, i < 30, 0, "wait_tick");
    step(0, 0, 1, 4'd1, 1, 0, 4'd3, 1, 0, "dmg_and_heal");
    step(0, 0, 0, 0, 1, 1, 4'd4, 1, 0, "hit_heal_tick");
    step(0, 0, 0, 0, 1, 0, 4'd5, 1, 0, "hit_heal");
    step(1, 0, 0, 0, 0, 0, 4'd10, 0, 0, "rst_mid_hit");
    while (exp_q.size() > 0) begin
      logic [5:0] e, o; string s;
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = tag_q.pop_front();
      ncmp++;
      if (o !== e) begin
        nerr++;
        $display("FAIL %s: got h=%0d hit=%0b dead=%0b, want h=%0d hit=%0b dead=%0b",
                 s, o[5:2], o[1], o[0], e[5:2], e[1], e[0]);
      end
    end
  endtask

  // Damage and frame_tick in the same ALIVE cycle: that tick is not counted,
  // so 30 further ticks are still required.
  task automatic test_back_to_back();
    step(0, 0, 1, 4'd1, 0, 1, 4'd9, 1, 0, "dmg_with_tick");
    for (int i = 1; i <= 30; i++)
      step(0, 0, 0, 0, 0, 1, 4'd9, i < 30, 0, "b2b_tick");
    step(0, 0, 0, 0, 1, 0, 4'd10, 0, 0, "alive_heal");
    while (exp_q.size() > 0) begin
      logic [5:0] e, o; string s;
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = tag_q.pop_front();
      ncmp++;
      if (o !== e) begin
        nerr++;
        $display("FAIL %s: got h=%0d hit=%0b dead=%0b, want h=%0d hit=%0b dead=%0b",
                 s, o[5:2], o[1], o[0], e[5:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_regen();
    step(0, 1, 0, 0, 0, 0, 4'd10, 0, 0, "regen_restart");
    step(0, 0, 1, 4'd2, 0, 0, 4'd8, 1, 0, "dmg2_to8");
    for (int i = 1; i <= 30; i++)
      step(0, 0, 0, 0, 0, 1, 4'd8, i < 30, 0, "wait_tick");
`ifdef HEALTH_TRACKER_REGEN_EN
    for (int i = 1; i <= 12; i++)
      step(0, 0, 0, 0, 0, 1, (i < 4) ? 4'd8 : (i < 8) ? 4'd9 : 4'd10, 0, 0, "regen_tick");
`else
    for (int i = 1; i <= 12; i++)
      step(0, 0, 0, 0, 0, 1, 4'd8, 0, 0, "no_regen_tick");
`endif
    while (exp_q.size() > 0) begin
      logic [5:0] e, o; string s;
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = tag_q.pop_front();
      ncmp++;
      if (o !== e) begin
        nerr++;
        $display("FAIL %s: got h=%0d hit=%0b dead=%0b, want h=%0d hit=%0b dead=%0b",
                 s, o[5:2], o[1], o[0], e[5:2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit_window();
    test_death();
    test_heal();
    test_back_to_back();
    test_regen();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/health_tracker.md
Name: health_tracker

Overview:
- Produces the `health` and `hit` signals that the HUD health bar renderer consumes.
- Tracks player health from collision-damage and heal pulses.
- After each hit, the player is invulnerable for a fixed number of frames; `hit` is asserted during that window so the bar shows red.
- Sits between the collision-detection logic and the HUD rendering path; all updates are synchronous to the pixel clock domain.

Parameters:
- MAX_HEALTH, 10: health value after reset/restart; legal range 1..15 (4-bit output).
- HIT_FRAMES, 30: length of the post-hit invulnerability/flash window, counted in frame_tick pulses; legal range 1..255.
- REGEN_FRAMES, 120: frames per passive +1 health step (only used with REGEN_EN); legal range 1..255.

Ports:
- clk  input  1  system/pixel clock.
- rst  input  1  synchronous, active-high reset.
- frame_tick  input  1  one-cycle pulse, once per video frame.
- damage  input  1  one-cycle pulse: a collision occurred.
- damage_amt  input  4  health to subtract on damage; sampled with damage.
- heal  input  1  one-cycle pulse: pickup collected, +1 health.
- restart  input  1  one-cycle pulse: new game.
- health  output  4  current health, 0..MAX_HEALTH.
- hit  output  1  high while in the HIT state.
- dead  output  1  high while in the DEAD state.

Behaviour:
- Reset is synchronous and active-high on `rst`, sampled on the rising edge of `clk`.
  - Reset gives: state=ALIVE, health=MAX_HEALTH, hit=0, dead=0, frame counter=0, regen counter=0.
- All outputs are registered. Effects of any input pulse are visible the cycle after it is sampled.
- Per-cycle priority: rst > restart > damage > heal > frame_tick-driven counters.
- restart is accepted in any state and behaves identically to rst.
- The state machine has three states: ALIVE, HIT and DEAD.
- ALIVE:
  - damage with damage_amt=0: no effect (no state change, no hit).
  - damage with damage_amt>0: health ← max(health − damage_amt, 0), using a saturating 4-bit subtract with no wrap.
    - Result 0 → DEAD.
    - Otherwise → HIT, with the frame counter cleared to 0.
  - heal (and no damage in the same cycle): health ← min(health+1, MAX_HEALTH).
- HIT:
  - hit=1 throughout. damage is ignored (invulnerable). heal is still applied, saturating at MAX_HEALTH.
  - Each frame_tick increments the frame counter.
  - On the tick that makes the counter reach HIT_FRAMES → ALIVE. hit drops the following cycle, so the HIT state spans exactly HIT_FRAMES ticks.
  - frame_tick and heal in the same cycle: both take effect.
- DEAD:
  - health=0, hit=0, dead=1.
  - damage, heal and frame_tick are ignored. Only restart or rst leaves DEAD.
- Simultaneous damage and heal in ALIVE: damage only; heal is dropped.
- Simultaneous damage and frame_tick in ALIVE: damage is processed and the frame counter starts at 0. That tick does not count toward HIT_FRAMES.
- health never exceeds MAX_HEALTH and never wraps below 0.

Optional Feature:
- Macro: HEALTH_TRACKER_REGEN_EN.
- When defined:
  - In ALIVE only, the regen counter increments on each frame_tick.
  - On reaching REGEN_FRAMES: the counter clears and health ← min(health+1, MAX_HEALTH).
  - The regen counter is cleared on entry to HIT, on entry to DEAD, on restart and on rst.
  - It holds (does not count) while health==MAX_HEALTH.
  - A regen step and a heal in the same cycle add +1 total, not +2.
- When undefined: no regen counter exists in hardware; REGEN_FRAMES is unused and health rises only via heal.

Test Plan:
- Reset, then 1 damage pulse with amt=3 → next cycle health=7, hit=1, dead=0.
- From HIT with HIT_FRAMES=30, issue 29 frame_ticks → hit stays 1.
  - 30th tick → hit=0 the following cycle, state ALIVE.
  - Damage pulses sent during the window leave health at 7.
- health=2, damage amt=5 → health=0, dead=1, hit=0.
  - Subsequent heal, damage and frame_tick leave outputs unchanged.
  - restart → health=10, dead=0 next cycle.
- health=10, heal → stays 10.
  - health=4 in ALIVE, damage amt=1 and heal in the same cycle → health=3, hit=1.
- With HEALTH_TRACKER_REGEN_EN and REGEN_FRAMES=4, health=8 in ALIVE, 4 frame_ticks → health=9.
  - 8 more ticks → health=10 and it holds there.
  - rst asserted mid-HIT → health=10, hit=0, dead=0 next cycle.
